// File: rtl/sccb_slave.sv
// SCCB register-access slave: 8-bit device address, 16-bit register address, burst read/write.
// Define SCCB_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on synchronized SCL/SDA.
module sccb_slave #(
    parameter logic [7:0] DEV_ADDR = 8'h78
) (
    input  logic        clk_25m,
    input  logic        camera_rstn,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic [8:0]  wr_count
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, ADH, ADH_ACK, ADL, ADL_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK
    } state_t;

    localparam logic [7:0] RD_ADDR = DEV_ADDR | 8'h01;

    // Sync flops reset to the idle-bus level so leaving reset creates no false edges
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_s, sda_s, scl_f, sda_f;

    always_ff @(posedge clk_25m or negedge camera_rstn) begin
        if (!camera_rstn) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

`ifdef SCCB_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_flt_q, sda_flt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk_25m or negedge camera_rstn) begin
        if (!camera_rstn) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s};
            sda_hist_q <= {sda_hist_q[0], sda_s};
            scl_flt_q  <= maj3(scl_s, scl_hist_q[0], scl_hist_q[1]);
            sda_flt_q  <= maj3(sda_s, sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    logic scl_q, sda_q;
    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        full_q, full_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  tx_q, tx_d;
    logic        rd_q, rd_d;
    logic        mack_q, mack_d;
    logic        fall_q, ld_q;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [8:0]  wrcnt_q, wrcnt_d;
    logic        busy_q, busy_d;
    logic        oe_q, oe_d;
    logic        re_c;

    always_ff @(posedge clk_25m or negedge camera_rstn) begin
        if (!camera_rstn) begin
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            full_q  <= 1'b0;
            sh_q    <= 8'h00;
            tx_q    <= 8'h00;
            rd_q    <= 1'b0;
            mack_q  <= 1'b0;
            fall_q  <= 1'b0;
            ld_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            wrcnt_q <= 9'd0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            scl_q   <= scl_f;
            sda_q   <= sda_f;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            mack_q  <= mack_d;
            fall_q  <= scl_fall;
            ld_q    <= re_c;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            wrcnt_q <= wrcnt_d;
            busy_q  <= busy_d;
            oe_q    <= oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        rd_d    = rd_q;
        mack_d  = mack_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        wrcnt_d = wrcnt_q;
        busy_d  = busy_q;
        oe_d    = oe_q;
        re_c    = 1'b0;

        if (we_q) addr_d = addr_q + 16'd1;
        if (ld_q) tx_d = reg_rdata;

        if (stop_c) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else if (start_c) begin
            state_d = DEV;
            busy_d  = 1'b1;
            cnt_d   = 3'd0;
            full_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            if (scl_rise) begin
                case (state_q)
                    DEV, ADH, ADL, WDAT: begin
                        sh_d  = {sh_q[6:0], sda_f};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) full_d = 1'b1;
                    end
                    RDAT: begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) full_d = 1'b1;
                    end
                    RDAT_ACK: begin
                        mack_d = ~sda_f;
                        if (!sda_f) addr_d = addr_q + 16'd1;
                    end
                    default: ;
                endcase
            end

            // Byte decisions and strobes happen on the SCL fall that ends a byte or ACK slot
            if (scl_fall) begin
                case (state_q)
                    DEV: if (full_q) begin
                        cnt_d  = 3'd0;
                        full_d = 1'b0;
                        if (sh_q == DEV_ADDR) begin
                            state_d = DEV_ACK;
                            rd_d    = 1'b0;
                        end else if (sh_q == RD_ADDR) begin
                            state_d = DEV_ACK;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    ADH: if (full_q) begin
                        addr_d[15:8] = sh_q;
                        state_d      = ADH_ACK;
                        cnt_d        = 3'd0;
                        full_d       = 1'b0;
                    end
                    ADL: if (full_q) begin
                        addr_d[7:0] = sh_q;
                        state_d     = ADL_ACK;
                        cnt_d       = 3'd0;
                        full_d      = 1'b0;
                    end
                    WDAT: if (full_q) begin
                        wdata_d = sh_q;
                        we_d    = 1'b1;
                        wrcnt_d = wrcnt_q + 9'd1;
                        state_d = WDAT_ACK;
                        cnt_d   = 3'd0;
                        full_d  = 1'b0;
                    end
                    DEV_ACK: begin
                        cnt_d  = 3'd0;
                        full_d = 1'b0;
                        if (rd_q) begin
                            state_d = RDAT;
                            re_c    = 1'b1;
                        end else begin
                            state_d = ADH;
                        end
                    end
                    ADH_ACK:  state_d = ADL;
                    ADL_ACK:  state_d = WDAT;
                    WDAT_ACK: state_d = WDAT;
                    RDAT: begin
                        if (full_q) begin
                            state_d = RDAT_ACK;
                            cnt_d   = 3'd0;
                            full_d  = 1'b0;
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                    RDAT_ACK: begin
                        cnt_d  = 3'd0;
                        full_d = 1'b0;
                        if (mack_q) begin
                            state_d = RDAT;
                            re_c    = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            // SDA only moves one cycle after the fall was seen, well inside SCL low
            if (fall_q) begin
                case (state_q)
                    DEV_ACK, ADH_ACK, ADL_ACK, WDAT_ACK: oe_d = 1'b1;
                    RDAT:    oe_d = ld_q ? ~reg_rdata[7] : ~tx_q[7];
                    default: oe_d = 1'b0;
                endcase
            end
        end
    end

    assign sda_oe    = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_c;
    assign busy      = busy_q;
    assign wr_count  = wrcnt_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: table of write transactions plus read, abort, reset and glitch sequences.
module tb_sccb_slave;

    logic        clk_25m = 1'b0;
    logic        camera_rstn = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic [7:0]  reg_rdata = 8'h56;
    logic        sda_oe, reg_we, reg_re, busy;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [8:0]  wr_count;

    assign sda_bus = sda_m & ~sda_oe;

    always #20 clk_25m = ~clk_25m;

    sccb_slave #(.DEV_ADDR(8'h78)) dut (
        .clk_25m(clk_25m), .camera_rstn(camera_rstn), .scl_i(scl), .sda_i(sda_bus),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy), .wr_count(wr_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int q = 10;

    // Monitor only appends; sequences remember where their own events start
    logic [15:0] we_addr[$];
    logic [7:0]  we_data[$];
    int          re_n = 0;
    logic [15:0] re_addr = 16'h0;
    int          ovl_n = 0;
    int          busy_cyc = 0;

    always @(negedge clk_25m) begin
        if (camera_rstn) begin
            if (reg_we) begin
                we_addr.push_back(reg_addr);
                we_data.push_back(reg_wdata);
            end
            if (reg_re) begin
                re_n++;
                re_addr = reg_addr;
            end
            if (reg_we && reg_re) ovl_n++;
            if (busy) busy_cyc++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wq();
        repeat (q) @(negedge clk_25m);
    endtask

    task automatic chk_outs_zero(input string nm);
        chk(nm, {27'd0, sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, wr_count}, 64'd0);
    endtask

    task automatic do_reset();
        camera_rstn = 1'b0;
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk_25m);
        chk_outs_zero("reset_outputs");
        camera_rstn = 1'b1;
        repeat (4) @(negedge clk_25m);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wq();
        scl = 1'b1;   wq();
        sda_m = 1'b0; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wq();
        scl = 1'b1;   wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic bit_x(input logic b, output logic s);
        sda_m = b;  wq();
        scl = 1'b1; wq();
        s = sda_bus; wq();
        scl = 1'b0; wq();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(d[i], s);
        bit_x(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            d[i] = s;
        end
        bit_x(nack, s);
    endtask

    typedef struct packed {
        int              qp;
        int              nb;
        logic [5:0][7:0] b;
        int              acks;
        int              nwe;
        logic [2:0][15:0] wa;
        logic [2:0][7:0]  wd;
        int              wrc;
    } vec_t;

    vec_t v[4];

    initial begin
        logic        a;
        int          acks, base;
        logic [7:0]  d;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        glitch_exp;

        // Write 78 30 08 82 at ~20 kHz
        v[0] = '{qp: 312, nb: 4, b: {8'h00, 8'h00, 8'h82, 8'h08, 8'h30, 8'h78}, acks: 4, nwe: 1,
                 wa: {16'h0, 16'h0, 16'h3008}, wd: {8'h0, 8'h0, 8'h82}, wrc: 1};
        // Foreign device address: nothing acknowledged, nothing written
        v[1] = '{qp: 10, nb: 4, b: {8'h00, 8'h00, 8'h82, 8'h08, 8'h30, 8'h42}, acks: 0, nwe: 0,
                 wa: '0, wd: '0, wrc: 0};
        // Burst write with address auto-increment
        v[2] = '{qp: 10, nb: 6, b: {8'hE2, 8'h0E, 8'h36, 8'h30, 8'h36, 8'h78}, acks: 6, nwe: 3,
                 wa: {16'h3632, 16'h3631, 16'h3630}, wd: {8'hE2, 8'h0E, 8'h36}, wrc: 3};
        // Address wrap FFFF -> 0000 inside a burst
        v[3] = '{qp: 10, nb: 5, b: {8'h00, 8'h22, 8'h11, 8'hFF, 8'hFF, 8'h78}, acks: 5, nwe: 2,
                 wa: {16'h0, 16'h0000, 16'hFFFF}, wd: {8'h0, 8'h22, 8'h11}, wrc: 2};

        for (int k = 0; k < 4; k++) begin
            do_reset();
            q = v[k].qp;
            base = we_addr.size();
            acks = 0;
            bus_start();
            for (int i = 0; i < v[k].nb; i++) begin
                wr_byte(v[k].b[i], a);
                acks += int'(a);
            end
            bus_stop();
            wq();
            chk($sformatf("v%0d_acks", k), acks, v[k].acks);
            chk($sformatf("v%0d_we_count", k), we_addr.size() - base, v[k].nwe);
            for (int j = 0; j < v[k].nwe; j++) begin
                ea = (base + j < we_addr.size()) ? we_addr[base + j] : 16'hDEAD;
                ed = (base + j < we_data.size()) ? we_data[base + j] : 8'hEE;
                chk($sformatf("v%0d_we%0d_addr", k, j), ea, v[k].wa[j]);
                chk($sformatf("v%0d_we%0d_data", k, j), ed, v[k].wd[j]);
            end
            chk($sformatf("v%0d_wr_count", k), wr_count, v[k].wrc);
            chk($sformatf("v%0d_busy_after_stop", k), busy, 1'b0);
            chk($sformatf("v%0d_sda_released", k), sda_oe, 1'b0);
        end
        chk("no_re_during_writes", re_n, 0);

        // Read: 78 30 0A, Sr 79, read one byte with master NACK
        do_reset();
        q = 10;
        base = we_addr.size();
        acks = 0;
        bus_start();
        wr_byte(8'h78, a); acks += int'(a);
        wr_byte(8'h30, a); acks += int'(a);
        wr_byte(8'h0A, a); acks += int'(a);
        bus_start();
        wr_byte(8'h79, a); acks += int'(a);
        rd_byte(1'b1, d);
        chk("rd_sda_after_nack", sda_oe, 1'b0);
        bus_stop();
        wq();
        chk("rd_acks", acks, 4);
        chk("rd_data_bits", d, 8'h56);
        chk("rd_re_count", re_n, 1);
        chk("rd_re_addr", re_addr, 16'h300A);
        chk("rd_no_we", we_addr.size() - base, 0);
        chk("rd_busy_after_stop", busy, 1'b0);

        // STOP in the middle of ADL aborts; a following write still works
        do_reset();
        base = we_addr.size();
        bus_start();
        wr_byte(8'h78, a);
        wr_byte(8'h30, a);
        for (int i = 0; i < 4; i++) bit_x(i[0] ? 1'b0 : 1'b1, a);
        bus_stop();
        wq();
        chk("abort_no_we", we_addr.size() - base, 0);
        chk("abort_busy", busy, 1'b0);
        acks = 0;
        bus_start();
        wr_byte(8'h78, a); acks += int'(a);
        wr_byte(8'h12, a); acks += int'(a);
        wr_byte(8'h34, a); acks += int'(a);
        wr_byte(8'hAB, a); acks += int'(a);
        bus_stop();
        wq();
        chk("post_abort_acks", acks, 4);
        chk("post_abort_we_count", we_addr.size() - base, 1);
        ea = (base < we_addr.size()) ? we_addr[base] : 16'hDEAD;
        ed = (base < we_data.size()) ? we_data[base] : 8'hEE;
        chk("post_abort_addr", ea, 16'h1234);
        chk("post_abort_data", ed, 8'hAB);
        chk("post_abort_wr_count", wr_count, 9'd1);

        // Reset while the read MSB (0) is pulling SDA low
        do_reset();
        bus_start();
        wr_byte(8'h78, a);
        wr_byte(8'h30, a);
        wr_byte(8'h0A, a);
        bus_start();
        wr_byte(8'h79, a);
        wq();
        chk("rst_pre_sda_driven", sda_oe, 1'b1);
        camera_rstn = 1'b0;
        #1;
        chk("rst_async_sda_release", sda_oe, 1'b0);
        chk_outs_zero("rst_async_outputs");
        do_reset();
        base = we_addr.size();
        acks = 0;
        bus_start();
        wr_byte(8'h78, a); acks += int'(a);
        wr_byte(8'h30, a); acks += int'(a);
        wr_byte(8'h08, a); acks += int'(a);
        wr_byte(8'h82, a); acks += int'(a);
        bus_stop();
        wq();
        chk("rst_then_write_acks", acks, 4);
        chk("rst_then_write_we", we_addr.size() - base, 1);

        // One-cycle SDA glitch while SCL is high
        do_reset();
        base = busy_cyc;
        sda_m = 1'b0;
        @(negedge clk_25m);
        sda_m = 1'b1;
        repeat (10) @(negedge clk_25m);
`ifdef SCCB_SLAVE_GLITCH_FILTER_EN
        glitch_exp = 1'b0;
`else
        glitch_exp = 1'b1;
`endif
        chk("glitch_seen_as_edge", busy_cyc != base, glitch_exp);
        chk("glitch_busy_cleared", busy, 1'b0);

        chk("we_re_overlap", ovl_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
